// File: rtl/launchpad_key_encoder_if.sv
// Event/pattern bus for launchpad_key_encoder: UART-facing valid/ready code stream
// plus the run-time pattern table write port.
interface launchpad_key_encoder_if #(
    parameter int NUM_KEYS = 16,
    parameter int LED_W    = 16,
    parameter int CODE_W   = 8
);
    localparam int ADDR_W = $clog2(NUM_KEYS);

    logic [CODE_W-1:0] tx_data;
    logic              tx_valid;
    logic              tx_ready;
    logic              pat_we;
    logic [ADDR_W-1:0] pat_addr;
    logic [LED_W-1:0]  pat_wdata;

    modport master (
        output tx_data, tx_valid,
        input  tx_ready, pat_we, pat_addr, pat_wdata
    );

    modport slave (
        input  tx_data, tx_valid,
        output tx_ready, pat_we, pat_addr, pat_wdata
    );
endinterface

// File: rtl/launchpad_key_encoder.sv
// Launch-pad key encoder: sync + shared debounce, press-edge priority encode, LED
// pattern lookup, event FIFO to UART. Optional release codes: LAUNCHPAD_RELEASE_CODE_EN.
module launchpad_key_encoder #(
    parameter int NUM_KEYS        = 16,
    parameter int LED_W           = 16,
    parameter int CODE_W          = 8,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int FIFO_DEPTH      = 4,
    parameter int LED_HOLD        = 0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NUM_KEYS-1:0] key_in,
    output logic [LED_W-1:0]    led_out,
    output logic [7:0]          drop_cnt,
    launchpad_key_encoder_if.master bus
);
    localparam int IDX_W = $clog2(NUM_KEYS);
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] CNT_TC   = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [PTR_W:0]   FIFO_MAX = (PTR_W+1)'(FIFO_DEPTH);

    logic [NUM_KEYS-1:0] sync_1, s, s_prev, d, d_prev;
    logic [CNT_W-1:0]    stable_cnt;
    logic [LED_W-1:0]    pat_table [NUM_KEYS];
    logic [CODE_W-1:0]   fifo_mem  [FIFO_DEPTH];
    logic [PTR_W-1:0]    wr_ptr, rd_ptr;
    logic [PTR_W:0]      fifo_cnt;

    logic [NUM_KEYS-1:0] press;
    logic                press_any;
    logic [IDX_W-1:0]    press_idx;
    logic                push_req;
    logic [CODE_W-1:0]   push_code;
    logic                lost;
    logic                fifo_full, pop, do_push, drop_push;
    logic [1:0]          drop_inc;
    logic [8:0]          drop_sum;

    assign press = d & ~d_prev;

    always_comb begin
        press_any = |press;
        press_idx = '0;
        for (int i = NUM_KEYS - 1; i >= 0; i--) begin
            if (press[i]) press_idx = IDX_W'(i);
        end
    end

`ifdef LAUNCHPAD_RELEASE_CODE_EN
    logic [NUM_KEYS-1:0] rel;
    logic                rel_any;
    logic [IDX_W-1:0]    rel_idx;

    assign rel = d_prev & ~d;

    always_comb begin
        rel_any = |rel;
        rel_idx = '0;
        for (int i = NUM_KEYS - 1; i >= 0; i--) begin
            if (rel[i]) rel_idx = IDX_W'(i);
        end
    end

    // A release coinciding with a press loses the slot and is counted as a drop.
    always_comb begin
        push_req  = press_any;
        push_code = CODE_W'(press_idx) + CODE_W'(1);
        lost      = press_any & rel_any;
        if (!press_any && rel_any) begin
            push_req  = 1'b1;
            push_code = (CODE_W'(rel_idx) + CODE_W'(1)) | (CODE_W'(1) << (CODE_W - 1));
        end
    end
`else
    always_comb begin
        push_req  = press_any;
        push_code = CODE_W'(press_idx) + CODE_W'(1);
        lost      = 1'b0;
    end
`endif

    assign fifo_full = (fifo_cnt == FIFO_MAX);
    assign pop       = bus.tx_valid & bus.tx_ready;
    assign do_push   = push_req & (~fifo_full | pop);
    assign drop_push = push_req & fifo_full & ~pop;
    assign drop_inc  = {1'b0, drop_push} + {1'b0, lost};
    assign drop_sum  = {1'b0, drop_cnt} + 9'(drop_inc);

    assign bus.tx_valid = (fifo_cnt != '0);
    assign bus.tx_data  = fifo_mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_1     <= '0;
            s          <= '0;
            s_prev     <= '0;
            d          <= '0;
            d_prev     <= '0;
            stable_cnt <= '0;
            led_out    <= '0;
            drop_cnt   <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_cnt   <= '0;
            for (int k = 0; k < FIFO_DEPTH; k++) fifo_mem[k] <= '0;
            for (int k = 0; k < NUM_KEYS; k++) pat_table[k] <= LED_W'(1) << (k % LED_W);
        end else begin
            sync_1 <= key_in;
            s      <= sync_1;
            s_prev <= s;
            d_prev <= d;

            if (s != s_prev) begin
                stable_cnt <= '0;
            end else begin
                if (stable_cnt != CNT_TC) stable_cnt <= stable_cnt + CNT_W'(1);
                if (stable_cnt == CNT_TC) d <= s;
            end

            // Lookup uses the pre-write table contents when a write hits the same entry.
            if (press_any) begin
                led_out <= pat_table[press_idx];
            end else if (LED_HOLD == 0 && d == '0 && d_prev != '0) begin
                led_out <= '0;
            end

            if (bus.pat_we && (32'(bus.pat_addr) < NUM_KEYS)) begin
                pat_table[bus.pat_addr] <= bus.pat_wdata;
            end

            if (do_push) begin
                fifo_mem[wr_ptr] <= push_code;
                wr_ptr           <= wr_ptr + PTR_W'(1);
            end
            if (pop) rd_ptr <= rd_ptr + PTR_W'(1);

            case ({do_push, pop})
                2'b10:   fifo_cnt <= fifo_cnt + (PTR_W+1)'(1);
                2'b01:   fifo_cnt <= fifo_cnt - (PTR_W+1)'(1);
                default: fifo_cnt <= fifo_cnt;
            endcase

            if (drop_inc != 2'd0) begin
                drop_cnt <= (drop_sum > 9'd255) ? 8'hFF : drop_sum[7:0];
            end
        end
    end
endmodule

// File: tb/tb_launchpad_key_encoder.sv
// Directed bench for launchpad_key_encoder with DEBOUNCE_CYCLES=4.
module tb_launchpad_key_encoder;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] key_in;
    logic [15:0] led_out;
    logic [7:0]  drop_cnt;
    int          checks = 0;
    int          failures = 0;

    launchpad_key_encoder_if #(.NUM_KEYS(16), .LED_W(16), .CODE_W(8)) bus ();

    launchpad_key_encoder #(
        .NUM_KEYS(16), .LED_W(16), .CODE_W(8),
        .DEBOUNCE_CYCLES(4), .FIFO_DEPTH(4), .LED_HOLD(0)
    ) dut (
        .clk(clk), .rst_n(rst_n), .key_in(key_in),
        .led_out(led_out), .drop_cnt(drop_cnt), .bus(bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] keys;
        logic [7:0]  code;
        logic [15:0] led;
    } vec_t;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_valid(input int budget);
        int n = 0;
        while (!bus.tx_valid && n < budget) begin
            tick();
            n++;
        end
        check("tx_valid_seen", bus.tx_valid, 1'b1);
    endtask

    task automatic press_release(input logic [15:0] keys);
        key_in = keys;
        repeat (10) tick();
        key_in = '0;
        repeat (10) tick();
    endtask

    vec_t vecs[6];
    int   ncodes;
    logic [7:0] last_code;

    initial begin
        vecs[0] = '{16'h0001, 8'h01, 16'h0001};
        vecs[1] = '{16'h0020, 8'h06, 16'h0020};
        vecs[2] = '{16'h8004, 8'h03, 16'h0004};
        vecs[3] = '{16'h0400, 8'h0B, 16'h0400};
        vecs[4] = '{16'h8000, 8'h10, 16'h8000};
        vecs[5] = '{16'h0030, 8'h05, 16'h0010};

        rst_n = 1'b0;
        key_in = '0;
        bus.tx_ready = 1'b1;
        bus.pat_we = 1'b0;
        bus.pat_addr = '0;
        bus.pat_wdata = '0;
        repeat (3) tick();
        rst_n = 1'b1;
        check("rst_led", led_out, 16'h0);
        check("rst_valid", bus.tx_valid, 1'b0);
        check("rst_data", bus.tx_data, 8'h00);
        check("rst_drop", drop_cnt, 8'h00);
        tick();

        // Exact press latency and release clear
        key_in = 16'h0001;
        repeat (7) tick();
        check("lat_valid_e7", bus.tx_valid, 1'b0);
        tick();
        check("lat_valid_e8", bus.tx_valid, 1'b1);
        check("lat_data", bus.tx_data, 8'h01);
        check("lat_led", led_out, 16'h0001);
        tick();
        check("lat_pulse_end", bus.tx_valid, 1'b0);
        key_in = '0;
        repeat (6) tick();
        check("rel_led_held", led_out, 16'h0001);
        repeat (2) tick();
        check("rel_led_clear", led_out, 16'h0000);
        repeat (4) tick();

        for (int i = 0; i < 6; i++) begin
            key_in = vecs[i].keys;
            wait_valid(20);
            check($sformatf("vec%0d_code", i), bus.tx_data, vecs[i].code);
            check($sformatf("vec%0d_led", i), led_out, vecs[i].led);
            tick();
            check($sformatf("vec%0d_single", i), bus.tx_valid, 1'b0);
            key_in = '0;
            repeat (12) tick();
        end

        // Bouncing input must not register until it settles
        ncodes = 0;
        last_code = '0;
        for (int i = 0; i < 10; i++) begin
            key_in[3] = ~key_in[3];
            repeat (2) begin
                tick();
                if (bus.tx_valid) begin ncodes++; last_code = bus.tx_data; end
            end
        end
        key_in[3] = 1'b1;
        repeat (20) begin
            tick();
            if (bus.tx_valid) begin ncodes++; last_code = bus.tx_data; end
        end
        check("bounce_count", ncodes, 1);
        check("bounce_code", last_code, 8'h04);
        key_in = '0;
        repeat (12) tick();

        // Pattern write, then press picks it up; later write leaves led_out alone
        bus.pat_we = 1'b1;
        bus.pat_addr = 4'd4;
        bus.pat_wdata = 16'h9F9F;
        tick();
        bus.pat_we = 1'b0;
        key_in = 16'h0010;
        wait_valid(20);
        check("pat_led", led_out, 16'h9F9F);
        check("pat_code", bus.tx_data, 8'h05);
        bus.pat_we = 1'b1;
        bus.pat_wdata = 16'h1111;
        tick();
        bus.pat_we = 1'b0;
        tick();
        check("pat_write_no_led", led_out, 16'h9F9F);
        key_in = '0;
        repeat (12) tick();

        // Full queue: 6 presses, 4 stored, 2 dropped
        bus.tx_ready = 1'b0;
        for (int i = 0; i < 6; i++) press_release(16'h0001 << i);
        check("full_valid", bus.tx_valid, 1'b1);
        check("full_head", bus.tx_data, 8'h01);
        check("full_drop", drop_cnt, 8'h02);
        tick();
        check("full_head_stable", bus.tx_data, 8'h01);
        bus.tx_ready = 1'b1;
        for (int j = 0; j < 4; j++) begin
            check($sformatf("drain%0d_valid", j), bus.tx_valid, 1'b1);
            check($sformatf("drain%0d_data", j), bus.tx_data, 8'(j + 1));
            tick();
        end
        check("drain_empty", bus.tx_valid, 1'b0);

        // Reset with a partly filled queue and a modified table entry
        bus.pat_we = 1'b1;
        bus.pat_addr = 4'd2;
        bus.pat_wdata = 16'hABCD;
        tick();
        bus.pat_we = 1'b0;
        bus.tx_ready = 1'b0;
        for (int i = 0; i < 3; i++) press_release(16'h0001 << i);
        check("pre_rst_valid", bus.tx_valid, 1'b1);
        check("pre_rst_led", led_out, 16'h0000);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("mid_rst_valid", bus.tx_valid, 1'b0);
        check("mid_rst_drop", drop_cnt, 8'h00);
        bus.tx_ready = 1'b1;
        key_in = 16'h0004;
        wait_valid(20);
        check("post_rst_code", bus.tx_data, 8'h03);
        check("post_rst_table2", led_out, 16'h0004);
        key_in = '0;
        repeat (12) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
